// File: rtl/dna_port_shifter_if.sv
// Signal bundle between dna_port_shifter and its surroundings: the read request,
// the DNA_PORT pins and the captured result.
interface dna_port_shifter_if #(
  parameter int DNA_WIDTH = 57
);
  // start_i is a level request; only its rising edge starts a read, and edges
  // arriving while busy_o is high are dropped. dna_o is meaningful only while
  // dna_valid_o is high, which holds until the next accepted start or reset.
  logic                 start_i;
  logic                 dna_dout_i;
  logic                 dna_clk_o;
  logic                 dna_read_o;
  logic                 dna_shift_o;
  logic                 dna_din_o;
  logic [DNA_WIDTH-1:0] dna_o;
  logic                 dna_valid_o;
  logic                 busy_o;

  modport master (
    output start_i, dna_dout_i,
    input  dna_clk_o, dna_read_o, dna_shift_o, dna_din_o, dna_o, dna_valid_o, busy_o
  );

  modport slave (
    input  start_i, dna_dout_i,
    output dna_clk_o, dna_read_o, dna_shift_o, dna_din_o, dna_o, dna_valid_o, busy_o
  );
endinterface

// File: rtl/dna_port_shifter.sv
// Drives DNA_PORT (CLK/READ/SHIFT) from the system clock and deserialises the
// device DNA, MSB first, into a parallel register with a valid flag.
module dna_port_shifter #(
  parameter int DNA_WIDTH = 57,
  parameter int CLK_DIV   = 4
) (
  input  logic                clk,
  input  logic                rst,
  dna_port_shifter_if.slave   bus,
  output logic [1:0]          fsm_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } state_t;

  localparam int DIV_W = $clog2(2 * CLK_DIV);
  localparam int BIT_W = $clog2(DNA_WIDTH + 1);
  localparam logic [DIV_W-1:0] RISE_AT  = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] FALL_AT  = DIV_W'(2 * CLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(DNA_WIDTH - 1);

  state_t               state;
  logic                 start_q;
  logic [DIV_W-1:0]     div_cnt;
  logic [BIT_W-1:0]     bit_cnt;
  logic [DNA_WIDTH-2:0] sr;
  logic                 start_edge;
  logic [DNA_WIDTH-1:0] next_word;

  assign start_edge    = bus.start_i & ~start_q;
  // The newest sample completes the word, so the register only keeps DNA_WIDTH-1 bits.
  assign next_word     = {sr, bus.dna_dout_i};
  assign bus.dna_din_o = 1'b0;
  assign fsm_state     = state;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      start_q         <= 1'b0;
      div_cnt         <= '0;
      bit_cnt         <= '0;
      sr              <= '0;
      bus.dna_clk_o   <= 1'b0;
      bus.dna_read_o  <= 1'b0;
      bus.dna_shift_o <= 1'b0;
      bus.dna_o       <= '0;
      bus.dna_valid_o <= 1'b0;
      bus.busy_o      <= 1'b0;
    end else begin
      start_q <= bus.start_i;
      case (state)
        IDLE: begin
          if (start_edge) begin
            state           <= LOAD;
            bus.busy_o      <= 1'b1;
            bus.dna_read_o  <= 1'b1;
            bus.dna_valid_o <= 1'b0;
            div_cnt         <= '0;
            bit_cnt         <= '0;
          end
        end
        LOAD, SHIFT: begin
          // Low phase first so READ/SHIFT have setup time before each rise.
          if (div_cnt == FALL_AT) begin
            div_cnt       <= '0;
            bus.dna_clk_o <= 1'b0;
            sr            <= next_word[DNA_WIDTH-2:0];
            bit_cnt       <= bit_cnt + 1'b1;
            if (state == LOAD) begin
              bus.dna_read_o  <= 1'b0;
              bus.dna_shift_o <= 1'b1;
              state           <= SHIFT;
            end else if (bit_cnt == LAST_BIT) begin
              bus.dna_o       <= next_word;
              bus.dna_valid_o <= 1'b1;
              bus.busy_o      <= 1'b0;
              bus.dna_shift_o <= 1'b0;
              state           <= IDLE;
            end
          end else begin
            div_cnt <= div_cnt + 1'b1;
            if (div_cnt == RISE_AT) bus.dna_clk_o <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dna_port_shifter.sv
// Bench for dna_port_shifter: two instances (CLK_DIV 4 and 2), each wired to a
// behavioural DNA_PORT model, exercised by a directed then randomised sequence.
module tb_dna_port_shifter;

  localparam int W = 57;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;
  int   sel      = 0;

  always #5 clk = ~clk;

  dna_port_shifter_if #(.DNA_WIDTH(W)) if0 ();
  dna_port_shifter_if #(.DNA_WIDTH(W)) if1 ();
  logic [1:0] st0, st1;

  dna_port_shifter #(.DNA_WIDTH(W), .CLK_DIV(4)) dut0 (.clk(clk), .rst(rst), .bus(if0.slave), .fsm_state(st0));
  dna_port_shifter #(.DNA_WIDTH(W), .CLK_DIV(2)) dut1 (.clk(clk), .rst(rst), .bus(if1.slave), .fsm_state(st1));

  // DNA_PORT model: READ loads the ID on a CLK rise, SHIFT moves it towards DOUT.
  logic [W-1:0] mdl0_val, mdl1_val, mdl0_sr, mdl1_sr;
  always @(posedge if0.dna_clk_o)
    if (if0.dna_read_o) mdl0_sr <= mdl0_val;
    else if (if0.dna_shift_o) mdl0_sr <= {mdl0_sr[W-2:0], if0.dna_din_o};
  always @(posedge if1.dna_clk_o)
    if (if1.dna_read_o) mdl1_sr <= mdl1_val;
    else if (if1.dna_shift_o) mdl1_sr <= {mdl1_sr[W-2:0], if1.dna_din_o};
  assign if0.dna_dout_i = mdl0_sr[W-1];
  assign if1.dna_dout_i = mdl1_sr[W-1];

  wire         m_busy  = (sel != 0) ? if1.busy_o      : if0.busy_o;
  wire         m_valid = (sel != 0) ? if1.dna_valid_o : if0.dna_valid_o;
  wire         m_dclk  = (sel != 0) ? if1.dna_clk_o   : if0.dna_clk_o;
  wire         m_read  = (sel != 0) ? if1.dna_read_o  : if0.dna_read_o;
  wire         m_shift = (sel != 0) ? if1.dna_shift_o : if0.dna_shift_o;
  wire [W-1:0] m_dna   = (sel != 0) ? if1.dna_o       : if0.dna_o;
  wire [W+5:0] all0    = {if0.dna_o, if0.dna_valid_o, if0.busy_o, if0.dna_clk_o,
                          if0.dna_read_o, if0.dna_shift_o, if0.dna_din_o};
  wire [W+5:0] all1    = {if1.dna_o, if1.dna_valid_o, if1.busy_o, if1.dna_clk_o,
                          if1.dna_read_o, if1.dna_shift_o, if1.dna_din_o};

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic set_start(input logic v);
    if (sel != 0) if1.start_i = v;
    else if0.start_i = v;
  endtask

  function automatic logic [W-1:0] rand_dna();
    logic [63:0] t;
    t = {$urandom, $urandom};
    return t[W-1:0];
  endfunction

  // One read on instance sel: the request is raised for start_len cycles; optional
  // extra edge at cycle inject_at of the read, or reset at cycle abort_at.
  task automatic run_read(input logic [W-1:0] val, input int start_len, input int inject_at,
                          input int abort_at, input string tag);
    int   div, lat_exp, t, cnt, pulses, bad, last_rise, idle_bad;
    logic pb, pc, done;
    div = (sel != 0) ? 2 : 4;
    lat_exp = 2 * div * W;
    t = 0; cnt = -1; pulses = 0; bad = 0; last_rise = -1; idle_bad = 0;
    pb = 1'b0; pc = 1'b0; done = 1'b0;
    if (sel != 0) mdl1_val = val;
    else mdl0_val = val;
    @(negedge clk);
    set_start(1'b1);
    while (!done && t < 4000) begin
      @(negedge clk);
      t++;
      if (t == start_len) set_start(1'b0);
      if (cnt >= 0) cnt++;
      if (m_busy && !pb && cnt < 0) begin
        cnt = 0;
        check({tag, "_valid_drop"}, m_valid, 0);
      end
      if (m_dclk && !pc) begin
        pulses++;
        if (pulses == 1 && !(m_read && !m_shift)) bad++;
        if (pulses > 1 && !(m_shift && !m_read)) bad++;
        if (last_rise >= 0 && t - last_rise != 2 * div) bad++;
        last_rise = t;
      end
      if (m_read && m_shift) bad++;
      if (inject_at > 0 && cnt == inject_at) set_start(1'b1);
      if (inject_at > 0 && cnt == inject_at + 4) set_start(1'b0);
      if (abort_at > 0 && cnt == abort_at) begin
        #2 rst = 1'b1;
        #1;
        check({tag, "_rst_out0"}, 64'(all0), 0);
        check({tag, "_rst_out1"}, 64'(all1), 0);
        set_start(1'b0);
        return;
      end
      if (cnt > 0 && m_valid) done = 1'b1;
      pb = m_busy;
      pc = m_dclk;
    end
    check({tag, "_done"}, done, 1);
    check({tag, "_latency"}, cnt, lat_exp);
    check({tag, "_pulses"}, pulses, W);
    check({tag, "_pins"}, bad, 0);
    check({tag, "_dna"}, m_dna, val);
    check({tag, "_busy_low"}, m_busy, 0);
    // A request still held high must not trigger another read.
    while (t < start_len) begin
      @(negedge clk);
      t++;
      if (m_busy || !m_valid || m_dclk) idle_bad++;
    end
    if (start_len > t - 1) begin
      set_start(1'b0);
      check({tag, "_held_idle"}, idle_bad, 0);
    end
  endtask

  initial begin
    rst = 1'b0;
    if0.start_i = 1'b0;
    if1.start_i = 1'b0;
    repeat (2) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("reset_out0", 64'(all0), 0);
    check("reset_out1", 64'(all1), 0);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_busy", if0.busy_o, 0);
    check("idle_state", st0, 0);

    sel = 0;
    run_read(57'h1_2345_6789_ABCD_EF, 4, 0, 0, "single");
    run_read(rand_dna(), 2000, 0, 0, "held");
    run_read(rand_dna(), 4, 100, 0, "inject");
    run_read(57'h0AA_AAAA_AAAA_AAAA, 2, 0, 0, "b2b");
    run_read(rand_dna(), 4, 0, 200, "abort");
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    run_read(rand_dna(), 4, 0, 0, "after_rst");

    sel = 1;
    run_read(57'h155_5555_5555_5555, 4, 0, 0, "div2");

    for (int i = 0; i < 4; i++) begin
      sel = i % 2;
      repeat ($urandom_range(0, 5)) @(negedge clk);
      run_read(rand_dna(), int'($urandom_range(1, 8)), 0, 0, "rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
